// File: rtl/udi_pow_seq.sv
// ---------------------------------------------------------------------------
// udi_pow_seq
//   Command sequencer in front of the UDI power/threshold datapath. It takes
//   one command at a time from the core, steers the datapath controls, waits
//   out the squarer latency, captures the result and returns it with the
//   command tag. It also counts consecutive above-threshold compare results
//   and raises a sticky detect flag used as a signal-present indication.
//
// Parameters
//   MULT_LAT  squarer pipeline depth, accept-to-valid-result cycles (1..15)
//   HIT_RUN   consecutive compare hits needed to set det_flag (1..255)
//   TAG_W     command/response tag width
//
// Ports
//   gclk, gresetn            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready      command handshake
//   cmd_op                   00 SETTHR, 01 POW, 10 CMP, 11 reserved
//   cmd_mode                 datapath sum mode for POW/CMP
//   cmd_tag                  echoed on rsp_tag
//   dp_thr_wr                threshold write strobe (accept cycle of SETTHR)
//   dp_sum_mode, dp_res_sel  datapath controls, held while a result settles
//   dp_rd                    datapath result
//   rsp_valid/rsp_ready      response handshake
//   rsp_data, rsp_tag        captured result and its tag
//   rsp_err                  reserved opcode was received
//   det_flag, det_clr        sticky detect flag and its clear
//
// gresetn release is expected to be synchronous to gclk (synchronised
// upstream); assertion takes effect immediately.
// ---------------------------------------------------------------------------
module udi_pow_seq #(
    parameter int MULT_LAT = 1,
    parameter int HIT_RUN  = 4,
    parameter int TAG_W    = 4
) (
    input  logic             gclk,
    input  logic             gresetn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [1:0]       cmd_mode,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic             dp_thr_wr,
    output logic [1:0]       dp_sum_mode,
    output logic             dp_res_sel,
    input  logic [31:0]      dp_rd,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err,
    output logic             det_flag,
    input  logic             det_clr
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [1:0] OP_SETTHR = 2'b00;
    localparam logic [1:0] OP_POW    = 2'b01;
    localparam logic [1:0] OP_CMP    = 2'b10;

    localparam logic [3:0] LAT_LOAD = 4'(MULT_LAT);
    localparam logic [7:0] HIT_MAX  = 8'(HIT_RUN);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [1:0]         r_op;
    logic [1:0]         r_mode;
    logic [3:0]         r_cnt;
    logic [3:0]         w_cnt_nxt;
    logic [31:0]        r_rsp_data;
    logic [TAG_W-1:0]   r_rsp_tag;
    logic               r_rsp_err;
    logic [7:0]         r_hit_cnt;
    logic               r_det_flag;

    logic               w_accept;
    logic               w_capture;
    logic               w_handshake;
    logic               w_thr_wr;
    logic [1:0]         w_sum_mode;
    logic               w_res_sel;

    logic               w_cmp_cap;
    logic [7:0]         w_hit_inc;
    logic               w_reach;
    logic [7:0]         w_hit_nxt;
    logic               w_det_nxt;

    assign cmd_ready   = (r_state == ST_IDLE);
    assign rsp_valid   = (r_state == ST_RESP);
    assign w_handshake = (r_state == ST_RESP) && rsp_ready;
    assign dp_thr_wr   = w_thr_wr;
    assign dp_sum_mode = w_sum_mode;
    assign dp_res_sel  = w_res_sel;
    assign rsp_data    = r_rsp_data;
    assign rsp_tag     = r_rsp_tag;
    assign rsp_err     = r_rsp_err;
    assign det_flag    = r_det_flag;

    // Next-state and datapath control decode. In the accept cycle the
    // controls follow the live command; in WAIT they come from the latched
    // copy so they stay stable until the result is sampled.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_thr_wr    = 1'b0;
        w_sum_mode  = 2'b00;
        w_res_sel   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_accept = 1'b1;
                    case (cmd_op)
                        OP_SETTHR: begin
                            w_thr_wr    = 1'b1;
                            w_state_nxt = ST_RESP;
                        end
                        OP_POW, OP_CMP: begin
                            w_sum_mode  = cmd_mode;
                            w_res_sel   = (cmd_op == OP_CMP);
                            w_cnt_nxt   = LAT_LOAD;
                            w_state_nxt = ST_WAIT;
                        end
                        default: begin
                            // reserved opcode: straight to an error response
                            w_state_nxt = ST_RESP;
                        end
                    endcase
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                w_sum_mode = r_mode;
                w_res_sel  = (r_op == OP_CMP);
                // counter value 1 marks cycle MULT_LAT, the result-valid cycle
                if (r_cnt <= 4'd1) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Hit-run tracking. A capture that reaches HIT_RUN overrides a
    // simultaneous det_clr so a detection is never lost.
    always_comb begin
        w_cmp_cap = w_capture && (r_op == OP_CMP);
        if (r_hit_cnt >= HIT_MAX) begin
            w_hit_inc = HIT_MAX;
        end else begin
            w_hit_inc = r_hit_cnt + 8'd1;
        end
        w_reach = w_cmp_cap && dp_rd[0] && (w_hit_inc == HIT_MAX);
        if (det_clr) begin
            w_hit_nxt = w_reach ? HIT_MAX : 8'd0;
            w_det_nxt = w_reach;
        end else if (w_cmp_cap) begin
            w_hit_nxt = dp_rd[0] ? w_hit_inc : 8'd0;
            w_det_nxt = r_det_flag || w_reach;
        end else begin
            w_hit_nxt = r_hit_cnt;
            w_det_nxt = r_det_flag;
        end
    end

    // FSM state and latency counter.
    always_ff @(posedge gclk or negedge gresetn) begin
        if (!gresetn) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Command latch and response registers.
    always_ff @(posedge gclk or negedge gresetn) begin
        if (!gresetn) begin
            r_op       <= 2'b00;
            r_mode     <= 2'b00;
            r_rsp_data <= 32'd0;
            r_rsp_tag  <= '0;
            r_rsp_err  <= 1'b0;
        end else if (w_accept) begin
            r_op       <= cmd_op;
            r_mode     <= cmd_mode;
            r_rsp_tag  <= cmd_tag;
            r_rsp_err  <= (cmd_op == 2'b11);
            r_rsp_data <= (cmd_op == 2'b11) ? 32'hFFFF_FFFF : 32'd0;
        end else if (w_capture) begin
            r_rsp_data <= dp_rd;
        end else if (w_handshake) begin
            r_op       <= 2'b00;
            r_mode     <= 2'b00;
            r_rsp_data <= 32'd0;
            r_rsp_tag  <= '0;
            r_rsp_err  <= 1'b0;
        end
    end

    // Detection state.
    always_ff @(posedge gclk or negedge gresetn) begin
        if (!gresetn) begin
            r_hit_cnt  <= 8'd0;
            r_det_flag <= 1'b0;
        end else begin
            r_hit_cnt  <= w_hit_nxt;
            r_det_flag <= w_det_nxt;
        end
    end

endmodule

// File: doc/udi_pow_seq.md
Name: udi_pow_seq

Overview:
- Sequencer in front of the UDI power/threshold datapath. It accepts one UDI power command at a time from the core-side requester and drives the datapath controls (threshold write, sum mode, result select).
- It waits out the squarer pipeline latency, captures the datapath result and returns it with a tag.
- It also tracks runs of consecutive above-threshold compare results and raises a sticky detect flag, which the core uses as a signal-present indication.

Parameters:
- MULT_LAT, 1, register stages in the 16x16 squarers; cycles from operand presentation to valid datapath result (1..15).
- HIT_RUN, 4, consecutive compare hits required to set det_flag (1..255).
- TAG_W, 4, width of the command/response tag.

Ports:
- gclk  in  1  block clock.
- gresetn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered; operands on in_rs/in_rt are valid to the datapath in the same cycle.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  2  00 SETTHR, 01 POW, 10 CMP, 11 reserved.
- cmd_mode  in  2  sum mode for POW/CMP: 00 none, 01 sum, 10 sum>>1, 11 bypass I.
- cmd_tag  in  TAG_W  returned unchanged with the response.
- dp_thr_wr  out  1  threshold register write enable to the datapath.
- dp_sum_mode  out  2  datapath sum-mode select.
- dp_res_sel  out  1  datapath result select: 1 = compare bit, 0 = sum.
- dp_rd  in  32  datapath result.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  32  captured result.
- rsp_tag  out  TAG_W  tag of the completed command.
- rsp_err  out  1  reserved opcode was received.
- det_flag  out  1  sticky detect flag.
- det_clr  in  1  clears det_flag and the hit counter.

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0 except cmd_ready=1; hit_cnt=0.
- States: IDLE, WAIT, RESP. Only one command is outstanding at a time; cmd_ready=1 only in IDLE.
- Accept is the cycle with cmd_valid & cmd_ready (call it cycle 0). cmd_op, cmd_mode and cmd_tag are latched at accept.
- SETTHR:
  - dp_thr_wr=1 in cycle 0 only (combinational from the accept condition).
  - Go to RESP; rsp_valid=1 from cycle 1 with rsp_data=0.
  - dp_sum_mode and dp_res_sel stay 0.
- POW / CMP:
  - dp_sum_mode=cmd_mode and dp_res_sel=(op==CMP), driven combinationally in cycle 0.
  - Both are then held from the latched registers through cycle MULT_LAT. The downstream logic is combinational, so the controls must be stable when the result is sampled.
  - A down-counter loaded with MULT_LAT at accept moves the state to WAIT.
  - dp_rd is captured into rsp_data at cycle MULT_LAT; rsp_valid=1 from cycle MULT_LAT+1.
- Reserved op (11): no datapath activity; rsp_valid at cycle 1 with rsp_data=32'hFFFF_FFFF and rsp_err=1.
- RESP:
  - rsp_valid, rsp_data, rsp_tag and rsp_err are held stable until rsp_ready.
  - On rsp_valid & rsp_ready, go to IDLE; cmd_ready=1 in the following cycle.
  - dp_sum_mode and dp_res_sel return to 0 outside POW/CMP cycles 0..MULT_LAT.
- Throughput: one command per MULT_LAT+2 cycles with rsp_ready tied high.
- Detection:
  - Updated only at the CMP capture cycle. dp_rd[0]=1 increments hit_cnt, saturating at HIT_RUN; dp_rd[0]=0 clears hit_cnt.
  - det_flag is set, and stays set, when hit_cnt reaches HIT_RUN.
  - POW and SETTHR do not touch hit_cnt.
- det_clr clears det_flag and hit_cnt. If det_clr coincides with a capture that would set det_flag, the set wins: det_flag=1, and hit_cnt=HIT_RUN if the increment reaches it.
- cmd_valid while not ready: ignored. The requester must hold the command; no state changes.
- gresetn asserted mid-command: the command is dropped, no response is produced, and all controls go to 0 immediately.

Test Plan:
- SETTHR with in_rs=0x0000_1000, tag=3 -> dp_thr_wr high exactly 1 cycle; rsp_valid at cycle 1, rsp_data=0, rsp_tag=3.
- POW mode=01, MULT_LAT=1, I=3, Q=4 -> dp_sum_mode=01 held cycles 0..1; rsp_data=25 at cycle 2. Repeat with mode=10 -> 12.
- CMP with threshold=100, HIT_RUN=4:
  - samples sum=200 ×3, then sum=50, then sum=200 ×4 -> det_flag stays 0 until the 4th consecutive hit of the second run, then 1.
  - det_clr pulse -> det_flag=0, hit_cnt=0.
- Back-pressure: POW response with rsp_ready low for 5 cycles -> rsp_data/rsp_tag stable, cmd_ready=0 throughout; accept resumes the cycle after the handshake.
- Reserved op=11, tag=7 -> rsp_err=1, rsp_data=0xFFFF_FFFF, no dp_thr_wr pulse, dp controls remain 0.
- gresetn pulled low during WAIT of a POW -> outputs 0 asynchronously, no rsp_valid after release, cmd_ready=1 on the first cycle after release.
